tlul_adapter_host_mo: RTL and testbench
=======================================

Name: tlul_adapter_host_mo

Overview:
Multiple-outstanding TL-UL host adapter. It converts a simple req/gnt/valid host port into TL-UL A/D channel transactions, with up to MAX_REQS requests in flight. Each request gets a unique a_source built from SRC_BASE plus a slot index. Responses may return out of order; they are matched to their slot by d_source and checked for opcode and protocol errors. It sits between a host core (DMA, debug, CPU data port) and the TL-UL crossbar.

Parameters:
- MAX_REQS, default 4: maximum outstanding transactions. Legal range 1..16.
- SRC_BASE, default 8'h00: base source ID. Its low $clog2(MAX_REQS) bits must be zero.
- SW, default $clog2(MAX_REQS) (minimum 1): slot index width. Derived; not overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  host request
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address
- we_i  in  1  write
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- size_i  in  2  log2 bytes
- valid_o  out  1  response valid (one-cycle pulse)
- rdata_o  out  32  read data
- rsp_id_o  out  SW  slot index of the returning response
- rsp_we_o  out  1  returning response belongs to a write
- err_o  out  1  response error (d_error or opcode mismatch)
- unexp_o  out  1  sticky: response seen with an unknown or idle source
- outstanding_o  out  SW+1  count of in-flight requests
- tl_o  out  102  A-channel bus, MSB first: a_valid[101] a_opcode[100:98] a_param[97:95] a_size[94:93] a_source[92:85] a_address[84:53] a_mask[52:49] a_data[48:17] a_user[16:1] d_ready[0]
- tl_i  in  68  D-channel bus, MSB first: d_valid[67] d_opcode[66:64] d_param[63:61] d_size[60:59] d_source[58:51] d_sink[50] d_data[49:18] d_user[17:2] d_error[1] a_ready[0]

Behaviour:
- Reset (rst_i high at a clock edge):
  - All slots become free; outstanding_o=0; unexp_o=0.
  - valid_o, err_o and rsp_* registers are cleared to 0.
  - During reset, a_valid=0 and gnt_o=0.
- State: per slot, a busy bit and a we bit.
- Full: full = all slots busy.
- A channel (combinational from the inputs and registered slot state):
  - a_valid = req_i & ~full & ~rst_i.
  - a_source = SRC_BASE | idx, where idx is the lowest-index free slot, taken from registered state.
  - a_opcode:
    - Get (3'h4) if ~we_i.
    - PutFullData (3'h0) if we_i and be_i==4'hF.
    - PutPartialData (3'h1) otherwise.
  - a_mask=be_i, a_size=size_i, a_address=addr_i, a_data=wdata_i, a_param=0, a_user=0.
  - d_ready is constant 1.
- Grant: gnt_o = a_valid & a_ready. On gnt_o, slot idx becomes busy and its we bit latches we_i at the clock edge.
- D channel: when d_valid=1, slot = d_source[SW-1:0].
  - Match: upper source bits equal SRC_BASE and the slot is busy.
  - Match response, registered one cycle later (latency 1 from d_valid):
    - valid_o=1, rdata_o=d_data, rsp_id_o=slot, rsp_we_o = the slot's we bit.
    - err_o = d_error | opcode mismatch. Expected d_opcode is AccessAckData (3'h1) for reads and AccessAck (3'h0) for writes.
    - The slot is freed at the same edge.
  - Non-match: no valid_o and no state change; unexp_o is set and stays set until reset.
- When valid_o=0, rdata_o/err_o hold their previous values; only the valid_o qualification is required.
- outstanding_o is +1 on grant, -1 on matched response, unchanged when both happen in the same cycle.
- Simultaneous grant and free:
  - A slot freed this cycle is not reallocated this cycle, because allocation uses registered state.
  - If the grant and the response target different slots, both take effect.
- Full: gnt_o=0 and a_valid=0 until some slot frees. A freed slot is usable on the next cycle.
- MAX_REQS=1: a strict one-in-flight adapter with an SW=1 index; slot 1 is never used.
- Reset mid-transaction: all slots are dropped. Late responses to pre-reset requests set unexp_o; they never produce valid_o.

Test Plan:
- Single read: req_i with addr 0x1000, we_i=0, a_ready=1 → gnt_o=1, a_opcode=4, a_source=0x00. Then a D response d_source=0x00, opcode 1, data 0xDEADBEEF → next cycle valid_o=1, rdata_o=0xDEADBEEF, err_o=0, outstanding_o back to 0.
- Partial write: we_i=1, be_i=4'h3 → a_opcode=1, a_mask=3. be_i=4'hF → a_opcode=0. Respond AccessAck → valid_o=1, rsp_we_o=1, err_o=0.
- Fill to full: MAX_REQS=4, four grants using sources 0,1,2,3 → outstanding_o=4, gnt_o=0 with req_i held. Return source 2 → the next cycle grants source 2.
- Out-of-order plus simultaneous events: respond to slot 3 in the same cycle as a new grant to slot 1 → outstanding_o unchanged, rsp_id_o=3.
- Errors: d_error=1 → err_o=1. A read answered with AccessAck → err_o=1. d_source=0x05 with slot 1 idle, or d_source=0x45 → unexp_o=1 and no valid_o.
- Reset with 3 outstanding: pulse rst_i → outstanding_o=0. A later response with source 0 → unexp_o=1 and valid_o stays 0.

Source files
------------

// File: rtl/tlul_adapter_host_mo.sv
// tlul_adapter_host_mo
// Multiple-outstanding TL-UL host adapter. A simple req/gnt host port is
// turned into TL-UL A-channel requests, each tagged with a per-slot source
// ID (SRC_BASE | slot). D-channel responses may come back in any order and
// are steered back to their slot by d_source, checked for protocol and
// opcode errors, and presented to the host as a one-cycle valid pulse.
module tlul_adapter_host_mo #(
  parameter int         MAX_REQS = 4,
  parameter logic [7:0] SRC_BASE = 8'h00,
  localparam int        SW       = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // host request port
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [31:0]   addr_i,
  input  logic          we_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  input  logic [1:0]    size_i,
  // host response port
  output logic          valid_o,
  output logic [31:0]   rdata_o,
  output logic [SW-1:0] rsp_id_o,
  output logic          rsp_we_o,
  output logic          err_o,
  output logic          unexp_o,
  output logic [SW:0]   outstanding_o,
  // TL-UL bus
  output logic [101:0]  tl_o,
  input  logic [67:0]   tl_i
);

  // TL-UL opcodes used on both channels.
  localparam logic [2:0] OP_GET          = 3'h4;
  localparam logic [2:0] OP_PUT_FULL     = 3'h0;
  localparam logic [2:0] OP_PUT_PARTIAL  = 3'h1;
  localparam logic [2:0] OP_ACCESS_ACK   = 3'h0;
  localparam logic [2:0] OP_ACCESS_ACK_D = 3'h1;

  // A-channel opcode: reads are Get, full-word writes PutFull, the rest PutPartial.
  function automatic logic [2:0] f_a_opcode(input logic we, input logic [3:0] be);
    logic [2:0] op;
    if (!we) begin
      op = OP_GET;
    end else if (be == 4'hF) begin
      op = OP_PUT_FULL;
    end else begin
      op = OP_PUT_PARTIAL;
    end
    return op;
  endfunction

  // Opcode the D channel must carry for a slot holding a read or a write.
  function automatic logic [2:0] f_d_expected(input logic slot_we);
    logic [2:0] op;
    if (slot_we) begin
      op = OP_ACCESS_ACK;
    end else begin
      op = OP_ACCESS_ACK_D;
    end
    return op;
  endfunction

  // Slot state
  logic [MAX_REQS-1:0] r_busy;
  logic [MAX_REQS-1:0] r_we;
  logic [SW:0]         r_outstanding;

  // Registered response outputs
  logic                r_valid;
  logic [31:0]         r_rdata;
  logic [SW-1:0]       r_rsp_id;
  logic                r_rsp_we;
  logic                r_err;
  logic                r_unexp;

  // D-channel field decode
  logic                w_d_valid;
  logic [2:0]          w_d_opcode;
  logic [7:0]          w_d_source;
  logic [31:0]         w_d_data;
  logic                w_d_error;
  logic                w_a_ready;
  logic                w_unused_tl;

  // Internal combinational nets
  logic                w_full;
  logic [SW-1:0]       w_alloc_idx;
  logic [7:0]          w_a_source;
  logic                w_a_valid;
  logic                w_gnt;
  logic [2:0]          w_a_opcode;
  logic [SW-1:0]       w_d_slot;
  logic                w_d_base_ok;
  logic                w_slot_busy;
  logic                w_slot_we;
  logic                w_match;
  logic                w_rsp_err;
  logic [MAX_REQS-1:0] w_set;
  logic [MAX_REQS-1:0] w_clr;

  assign w_d_valid  = tl_i[67];
  assign w_d_opcode = tl_i[66:64];
  assign w_d_source = tl_i[58:51];
  assign w_d_data   = tl_i[49:18];
  assign w_d_error  = tl_i[1];
  assign w_a_ready  = tl_i[0];
  // d_param, d_size, d_sink and d_user carry nothing this adapter needs.
  assign w_unused_tl = ^{tl_i[63:59], tl_i[50], tl_i[17:2]};

  assign w_full = &r_busy;

  // Pick the lowest-index free slot; scanning downward lets the lowest win.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = MAX_REQS - 1; i >= 0; i--) begin
      w_alloc_idx = r_busy[i] ? w_alloc_idx : i[SW-1:0];
    end
  end

  assign w_a_source = SRC_BASE | {{(8 - SW){1'b0}}, w_alloc_idx};
  assign w_a_valid  = req_i & ~w_full & ~rst_i;
  assign w_gnt      = w_a_valid & w_a_ready;
  assign w_a_opcode = f_a_opcode(we_i, be_i);

  // Response routing: low source bits select the slot, high bits must be ours.
  assign w_d_slot    = w_d_source[SW-1:0];
  assign w_d_base_ok = (w_d_source[7:SW] == SRC_BASE[7:SW]);

  // Look up busy/we of the addressed slot; indices past MAX_REQS read as idle.
  always_comb begin
    w_slot_busy = 1'b0;
    w_slot_we   = 1'b0;
    for (int i = 0; i < MAX_REQS; i++) begin
      w_slot_busy = (w_d_slot == i[SW-1:0]) ? r_busy[i] : w_slot_busy;
      w_slot_we   = (w_d_slot == i[SW-1:0]) ? r_we[i]   : w_slot_we;
    end
  end

  assign w_match   = w_d_valid & w_d_base_ok & w_slot_busy;
  assign w_rsp_err = w_d_error | (w_d_opcode != f_d_expected(w_slot_we));

  // One-hot masks of the slot being allocated and the slot being retired.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < MAX_REQS; i++) begin
      w_set[i] = w_gnt   & (w_alloc_idx == i[SW-1:0]);
      w_clr[i] = w_match & (w_d_slot    == i[SW-1:0]);
    end
  end

  // Slot bookkeeping: allocate on grant, retire on matched response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
      r_we   <= '0;
    end else begin
      r_busy <= (r_busy | w_set) & ~w_clr;
      r_we   <= (r_we & ~w_set) | (w_set & {MAX_REQS{we_i}});
    end
  end

  // In-flight counter; a grant and a retirement in one cycle cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_gnt, w_match})
        2'b10:   r_outstanding <= r_outstanding + {{SW{1'b0}}, 1'b1};
        2'b01:   r_outstanding <= r_outstanding - {{SW{1'b0}}, 1'b1};
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Response register: pulse valid for a matched response, hold payload otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_rdata  <= 32'h0;
      r_rsp_id <= '0;
      r_rsp_we <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_match) begin
      r_valid  <= 1'b1;
      r_rdata  <= w_d_data;
      r_rsp_id <= w_d_slot;
      r_rsp_we <= w_slot_we;
      r_err    <= w_rsp_err;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  // Sticky flag for responses that do not belong to any live slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_unexp <= 1'b0;
    end else if (w_d_valid && !w_match) begin
      r_unexp <= 1'b1;
    end else begin
      r_unexp <= r_unexp;
    end
  end

  assign gnt_o         = w_gnt;
  assign valid_o       = r_valid;
  assign rdata_o       = r_rdata;
  assign rsp_id_o      = r_rsp_id;
  assign rsp_we_o      = r_rsp_we;
  assign err_o         = r_err;
  assign unexp_o       = r_unexp;
  assign outstanding_o = r_outstanding;

  // A channel, MSB first; d_ready is tied high since responses are never stalled.
  assign tl_o = {w_a_valid, w_a_opcode, 3'h0, size_i, w_a_source, addr_i,
                 be_i, wdata_i, 16'h0000, 1'b1};

endmodule

// File: tb/tb_tlul_adapter_host_mo.sv
// Bench for tlul_adapter_host_mo: directed scenarios plus a randomized run,
// all checked against a slot-table reference model.
module tb_tlul_adapter_host_mo;
  localparam int         N       = 4;
  localparam int         SW      = 2;
  localparam logic [7:0] TB_BASE = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req, we;
  logic [31:0]   addr, wdata;
  logic [3:0]    be;
  logic [1:0]    size;
  logic          gnt, valid, rsp_we, err, unexp;
  logic [31:0]   rdata;
  logic [SW-1:0] rsp_id;
  logic [SW:0]   outstanding;
  logic [101:0]  tl_o;
  logic [67:0]   tl_i;
  logic          d_valid, d_error, a_ready;
  logic [2:0]    d_opcode;
  logic [7:0]    d_source;
  logic [31:0]   d_data;
  logic [21:0]   d_junk;

  assign tl_i = {d_valid, d_opcode, d_junk[21:19], d_junk[18:17], d_source,
                 d_junk[16], d_data, d_junk[15:0], d_error, a_ready};

  wire        a_valid  = tl_o[101];
  wire [2:0]  a_opcode = tl_o[100:98];
  wire [2:0]  a_param  = tl_o[97:95];
  wire [1:0]  a_size   = tl_o[94:93];
  wire [7:0]  a_source = tl_o[92:85];
  wire [31:0] a_addr   = tl_o[84:53];
  wire [3:0]  a_mask   = tl_o[52:49];
  wire [31:0] a_data   = tl_o[48:17];
  wire [15:0] a_user   = tl_o[16:1];
  wire        d_ready  = tl_o[0];

  tlul_adapter_host_mo #(.MAX_REQS(N), .SRC_BASE(TB_BASE)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .be_i(be), .size_i(size), .valid_o(valid),
    .rdata_o(rdata), .rsp_id_o(rsp_id), .rsp_we_o(rsp_we), .err_o(err),
    .unexp_o(unexp), .outstanding_o(outstanding), .tl_o(tl_o), .tl_i(tl_i)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  bit          m_busy[N];
  bit          m_we[N];
  bit          m_unexp;
  bit          e_valid, e_we, e_err, e_gnt, e_avalid;
  logic [31:0] e_rdata;
  int          e_id, e_src;
  logic [2:0]  e_op;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_busy[i] ? 1 : 0;
    return c;
  endfunction

  task automatic mdl_comb();
    e_src = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) e_src = i;
    e_avalid = req && !rst && (e_src >= 0);
    e_gnt    = e_avalid && a_ready;
    e_op     = !we ? 3'h4 : ((be == 4'hF) ? 3'h0 : 3'h1);
  endtask

  task automatic mdl_edge();
    int s;
    bit hit;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_we[i] = 0; end
      m_unexp = 0; e_valid = 0;
    end else begin
      s = int'(d_source) - int'(TB_BASE);
      hit = 0;
      if (d_valid && s >= 0 && s < N) hit = m_busy[s];
      if (hit) begin
        e_valid = 1; e_rdata = d_data; e_id = s; e_we = m_we[s];
        e_err = d_error || (d_opcode != (m_we[s] ? 3'h0 : 3'h1));
      end else begin
        e_valid = 0;
      end
      if (d_valid && !hit) m_unexp = 1;
      if (e_gnt) begin m_busy[e_src] = 1; m_we[e_src] = we; end
      if (hit) m_busy[s] = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    req = 0; we = 0; addr = 32'h0; wdata = 32'h0; be = 4'hF; size = 2'd2;
    a_ready = 1; d_valid = 0; d_opcode = 3'h0; d_source = 8'h00;
    d_data = 32'h0; d_error = 0; d_junk = 22'h0;
  endtask

  task automatic settle();
    #1; mdl_comb();
  endtask

  task automatic tick();
    mdl_comb();
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  task automatic respond(input logic [7:0] src, input logic [2:0] op,
                         input logic [31:0] data, input logic derr);
    d_valid = 1; d_source = src; d_opcode = op; d_data = data; d_error = derr;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs(); rst = 1; req = 1;
    settle();
    checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b want=0", gnt); end
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_avalid got=%b want=0", a_valid); end
    tick(); tick();
    rst = 0; req = 0;
    settle();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
    checks++; if (unexp !== 1'b0) begin failures++; $display("FAIL reset_unexp got=%b want=0", unexp); end
    checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL reset_dready got=%b want=1", d_ready); end
  endtask

  task automatic test_single_read();
    idle_inputs(); req = 1; addr = 32'h0000_1000; size = 2'd2;
    settle();
    checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt got=%b want=1", gnt); end
    checks++; if (a_opcode !== 3'h4) begin failures++; $display("FAIL rd_opcode got=%0h want=4", a_opcode); end
    checks++; if (a_source !== 8'h00) begin failures++; $display("FAIL rd_source got=%0h want=0", a_source); end
    checks++; if (a_addr !== 32'h1000) begin failures++; $display("FAIL rd_addr got=%0h want=1000", a_addr); end
    checks++; if ({a_param, a_user, a_size} !== {3'h0, 16'h0, 2'd2}) begin failures++; $display("FAIL rd_fields got=%0h/%0h/%0h", a_param, a_user, a_size); end
    tick(); req = 0;
    settle();
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL rd_out1 got=%0d want=1", outstanding); end
    respond(8'h00, 3'h1, 32'hDEAD_BEEF, 1'b0);
    tick(); d_valid = 0;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL rd_valid got=%b want=1", valid); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata got=%0h want=deadbeef", rdata); end
    checks++; if ({err, rsp_we, rsp_id} !== 4'b0000) begin failures++; $display("FAIL rd_meta got=%b%b%0d want=000", err, rsp_we, rsp_id); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL rd_out0 got=%0d want=0", outstanding); end
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b want=0", valid); end
  endtask

  task automatic test_write();
    idle_inputs(); req = 1; we = 1; be = 4'h3; wdata = 32'hA5A5_1234;
    settle();
    checks++; if (a_opcode !== 3'h1) begin failures++; $display("FAIL wr_partial_op got=%0h want=1", a_opcode); end
    checks++; if (a_mask !== 4'h3) begin failures++; $display("FAIL wr_mask got=%0h want=3", a_mask); end
    checks++; if (a_data !== 32'hA5A5_1234) begin failures++; $display("FAIL wr_data got=%0h want=a5a51234", a_data); end
    tick(); be = 4'hF;
    settle();
    checks++; if (a_opcode !== 3'h0) begin failures++; $display("FAIL wr_full_op got=%0h want=0", a_opcode); end
    checks++; if (a_source !== 8'h01) begin failures++; $display("FAIL wr_source got=%0h want=1", a_source); end
    tick(); req = 0;
    respond(8'h01, 3'h0, 32'h0, 1'b0);
    tick();
    checks++; if ({valid, rsp_we, err, rsp_id} !== 5'b11001) begin failures++; $display("FAIL wr_rsp1 got=%b%b%b%0d want=1101", valid, rsp_we, err, rsp_id); end
    respond(8'h00, 3'h0, 32'h0, 1'b0);
    tick(); d_valid = 0;
    checks++; if ({valid, rsp_we, err, rsp_id} !== 5'b11000) begin failures++; $display("FAIL wr_rsp0 got=%b%b%b%0d want=1100", valid, rsp_we, err, rsp_id); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL wr_out got=%0d want=0", outstanding); end
  endtask

  task automatic test_fill_full();
    idle_inputs(); req = 1;
    for (int k = 0; k < N; k++) begin
      settle();
      checks++; if (gnt !== 1'b1 || a_source !== 8'(k)) begin failures++; $display("FAIL fill_grant%0d got=%b/%0h want=1/%0h", k, gnt, a_source, k); end
      tick();
    end
    settle();
    checks++; if ({gnt, a_valid} !== 2'b00) begin failures++; $display("FAIL full_block got=%b%b want=00", gnt, a_valid); end
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL full_out got=%0d want=4", outstanding); end
    respond(8'h02, 3'h1, 32'h0000_0222, 1'b0);
    settle();
    checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL full_samecycle got=%b want=0", gnt); end
    tick(); d_valid = 0;
    checks++; if (valid !== 1'b1 || rsp_id !== 2'd2) begin failures++; $display("FAIL full_rsp got=%b/%0d want=1/2", valid, rsp_id); end
    settle();
    checks++; if (gnt !== 1'b1 || a_source !== 8'h02) begin failures++; $display("FAIL full_regrant got=%b/%0h want=1/2", gnt, a_source); end
    tick(); req = 0;
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL full_out2 got=%0d want=4", outstanding); end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    respond(8'h01, 3'h1, 32'h1111, 1'b0);
    tick(); d_valid = 0;
    req = 1; respond(8'h03, 3'h1, 32'h3333, 1'b0);
    settle();
    checks++; if (gnt !== 1'b1 || a_source !== 8'h01) begin failures++; $display("FAIL simul_grant got=%b/%0h want=1/1", gnt, a_source); end
    tick();
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL simul_out got=%0d want=3", outstanding); end
    checks++; if (valid !== 1'b1 || rsp_id !== 2'd3) begin failures++; $display("FAIL simul_rsp got=%b/%0d want=1/3", valid, rsp_id); end
    respond(8'h00, 3'h1, 32'h0, 1'b0);
    settle();
    checks++; if (a_source !== 8'h03) begin failures++; $display("FAIL simul_noreuse got=%0h want=3", a_source); end
    tick(); req = 0;
    for (int s = 1; s < N; s++) begin
      respond(8'(s), 3'h1, 32'(s), 1'b0);
      tick();
      checks++; if (valid !== 1'b1 || rsp_id !== 2'(s)) begin failures++; $display("FAIL drain%0d got=%b/%0d", s, valid, rsp_id); end
    end
    d_valid = 0; tick();
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL simul_drain got=%0d want=0", outstanding); end
  endtask

  task automatic test_errors();
    idle_inputs(); req = 1; tick(); req = 0;
    respond(8'h00, 3'h1, 32'h0, 1'b1); tick(); d_valid = 0;
    checks++; if (valid !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL err_derror got=%b/%b want=1/1", valid, err); end
    req = 1; tick(); req = 0;
    respond(8'h00, 3'h0, 32'h0, 1'b0); tick(); d_valid = 0;
    checks++; if (valid !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL err_rd_ack got=%b/%b want=1/1", valid, err); end
    req = 1; we = 1; tick(); req = 0; we = 0;
    respond(8'h00, 3'h1, 32'h0, 1'b0); tick(); d_valid = 0;
    checks++; if (valid !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL err_wr_ackd got=%b/%b want=1/1", valid, err); end
    respond(8'h05, 3'h1, 32'h0, 1'b0); tick(); d_valid = 0;
    checks++; if (valid !== 1'b0 || unexp !== 1'b1) begin failures++; $display("FAIL unexp_idle got=%b/%b want=0/1", valid, unexp); end
    rst = 1; tick(); rst = 0;
    checks++; if (unexp !== 1'b0) begin failures++; $display("FAIL unexp_clear got=%b want=0", unexp); end
    req = 1; tick(); tick(); req = 0;
    respond(8'h45, 3'h1, 32'h0, 1'b0); tick(); d_valid = 0;
    checks++; if (valid !== 1'b0 || unexp !== 1'b1 || outstanding !== 3'd2) begin failures++; $display("FAIL unexp_base got=%b/%b/%0d want=0/1/2", valid, unexp, outstanding); end
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset_mid();
    idle_inputs(); req = 1; tick(); tick(); tick(); req = 0;
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL mid_out3 got=%0d want=3", outstanding); end
    rst = 1; tick(); rst = 0;
    checks++; if (outstanding !== 3'd0 || valid !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0d/%b want=0/0", outstanding, valid); end
    respond(8'h00, 3'h1, 32'h1234, 1'b0); tick(); d_valid = 0;
    checks++; if (valid !== 1'b0 || unexp !== 1'b1) begin failures++; $display("FAIL mid_late got=%b/%b want=0/1", valid, unexp); end
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_random();
    int pick;
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 99) < 2);
      req     = ($urandom_range(0, 99) < 60);
      we      = $urandom_range(0, 1) != 0;
      be      = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      addr    = $urandom; wdata = $urandom; size = 2'($urandom_range(0, 3));
      a_ready = ($urandom_range(0, 99) < 75);
      d_junk  = 22'($urandom);
      d_data  = $urandom;
      d_error = ($urandom_range(0, 99) < 10);
      d_valid = ($urandom_range(0, 99) < 45);
      pick = -1;
      for (int t = 0; t < 8; t++) begin
        int s = $urandom_range(0, N - 1);
        if (pick < 0 && m_busy[s]) pick = s;
      end
      if ($urandom_range(0, 99) < 8 || pick < 0) d_source = 8'($urandom_range(0, 255));
      else d_source = TB_BASE | 8'(pick);
      if ($urandom_range(0, 99) < 85 && pick >= 0) d_opcode = m_we[pick] ? 3'h0 : 3'h1;
      else d_opcode = 3'($urandom_range(0, 7));
      settle();
      checks++; if (gnt !== e_gnt || a_valid !== e_avalid) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b%b want=%b%b", c, gnt, a_valid, e_gnt, e_avalid); end
      checks++; if (a_opcode !== e_op || a_mask !== be) begin failures++; $display("FAIL rnd_op c=%0d got=%0h/%0h want=%0h/%0h", c, a_opcode, a_mask, e_op, be); end
      if (e_avalid) begin
        checks++; if (a_source !== TB_BASE + 8'(e_src)) begin failures++; $display("FAIL rnd_src c=%0d got=%0h want=%0h", c, a_source, e_src); end
      end
      tick();
      checks++; if (valid !== e_valid || unexp !== m_unexp) begin failures++; $display("FAIL rnd_flags c=%0d got=%b%b want=%b%b", c, valid, unexp, e_valid, m_unexp); end
      checks++; if (outstanding !== 3'(m_count())) begin failures++; $display("FAIL rnd_out c=%0d got=%0d want=%0d", c, outstanding, m_count()); end
      if (e_valid) begin
        checks++; if (rdata !== e_rdata || rsp_id !== 2'(e_id) || rsp_we !== e_we || err !== e_err) begin
          failures++; $display("FAIL rnd_rsp c=%0d got=%0h/%0d/%b/%b want=%0h/%0d/%b/%b", c, rdata, rsp_id, rsp_we, err, e_rdata, e_id, e_we, e_err);
        end
      end
    end
    rst = 1; idle_inputs(); tick(); rst = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_we[i] = 0; end
    m_unexp = 0; e_valid = 0; e_we = 0; e_err = 0; e_rdata = 32'h0; e_id = 0;
    rst = 1; idle_inputs();
    test_reset();
    test_single_read();
    test_write();
    test_fill_full();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
